// File: rtl/mac_port_arbiter.sv
// rtl/mac_port_arbiter.sv - per-port holding registers, round-robin grant, per-port outstanding limit
module mac_port_arbiter #(
    parameter int MEM_ACC_PORT_COUNT = 2,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MEM_ACC_PORT_COUNT-1:0]    prt_tx_av,
    output logic [MEM_ACC_PORT_COUNT-1:0]    prt_tx_re,
    input  logic [MEM_ACC_PORT_COUNT*32-1:0] prt_tx_addr,
    input  logic [MEM_ACC_PORT_COUNT*128-1:0] prt_tx_dat,
    input  logic [MEM_ACC_PORT_COUNT-1:0]    prt_tx_wr,
    output logic                             oup_rp,
    output logic [164:0]                     oup_req,
    input  logic                             oup_ra,
    input  logic                             cmp_valid,
    input  logic [3:0]                       cmp_orig,
    output logic                             cnt_err
);

    localparam int N  = MEM_ACC_PORT_COUNT;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    logic [N-1:0]    hold_v;
    logic [164:0]    hold [N];
    logic [CW-1:0]   out_cnt [N];
    logic [PW-1:0]   rr_ptr;

    logic [N-1:0]    eligible;
    logic [N-1:0]    grant;
    logic [N-1:0]    cnt_dec;
    logic [PW-1:0]   sel;
    logic [PW-1:0]   scan_idx;
    logic            found;
    logic            out_free;
    logic            cmp_in_range;
    logic            zero_hit;
    int              scan_sum;
    int              next_ptr;

    assign out_free     = !oup_rp || oup_ra;
    assign cmp_in_range = {1'b0, cmp_orig} < 5'(N);
    assign prt_tx_re    = ~hold_v | grant;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            eligible[p] = hold_v[p] && (out_cnt[p] < CNT_MAX);
        end
    end

    // Scan starts at rr_ptr and wraps, so the port after the last winner has first claim.
    always_comb begin
        found    = 1'b0;
        sel      = '0;
        scan_idx = '0;
        scan_sum = 0;
        grant    = '0;
        for (int i = 0; i < N; i++) begin
            scan_sum = (int'(rr_ptr) + i) % N;
            scan_idx = scan_sum[PW-1:0];
            if (out_free && !found && eligible[scan_idx]) begin
                found = 1'b1;
                sel   = scan_idx;
            end
        end
        if (found) begin
            grant[sel] = 1'b1;
        end
        next_ptr = (int'(sel) + 1) % N;
    end

    always_comb begin
        cnt_dec  = '0;
        zero_hit = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (cmp_valid && cmp_in_range && cmp_orig == 4'(p)) begin
                if (out_cnt[p] != '0) begin
                    cnt_dec[p] = 1'b1;
                end else begin
                    zero_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_v  <= '0;
            rr_ptr  <= '0;
            oup_rp  <= 1'b0;
            oup_req <= '0;
            cnt_err <= 1'b0;
            for (int p = 0; p < N; p++) begin
                out_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < N; p++) begin
                if (prt_tx_av[p] && prt_tx_re[p]) begin
                    hold[p]   <= {prt_tx_addr[p*32 +: 32], prt_tx_dat[p*128 +: 128], 4'(p), prt_tx_wr[p]};
                    hold_v[p] <= 1'b1;
                end else if (grant[p]) begin
                    hold_v[p] <= 1'b0;
                end
                // A grant and a completion on the same port cancel out.
                if (grant[p] && !cnt_dec[p]) begin
                    out_cnt[p] <= out_cnt[p] + CW'(1);
                end else if (cnt_dec[p] && !grant[p]) begin
                    out_cnt[p] <= out_cnt[p] - CW'(1);
                end
            end
            if (cmp_valid && (!cmp_in_range || zero_hit)) begin
                cnt_err <= 1'b1;
            end
            if (out_free) begin
                if (found) begin
                    oup_req <= hold[sel];
                    oup_rp  <= 1'b1;
                    rr_ptr  <= next_ptr[PW-1:0];
                end else begin
                    oup_rp  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_port_arbiter.sv
// tb/tb_mac_port_arbiter.sv - random and directed stimulus against a queue-based scoreboard model
module tb_mac_port_arbiter;

    localparam int N   = 2;
    localparam int MAX = 2;
    typedef logic [164:0] req_t;

    logic           clk;
    logic           rst;
    logic [N-1:0]   prt_tx_av;
    logic [N-1:0]   prt_tx_re;
    logic [N*32-1:0]  prt_tx_addr;
    logic [N*128-1:0] prt_tx_dat;
    logic [N-1:0]   prt_tx_wr;
    logic           oup_rp;
    req_t           oup_req;
    logic           oup_ra;
    logic           cmp_valid;
    logic [3:0]     cmp_orig;
    logic           cnt_err;

    mac_port_arbiter #(.MEM_ACC_PORT_COUNT(N), .MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst(rst),
        .prt_tx_av(prt_tx_av), .prt_tx_re(prt_tx_re),
        .prt_tx_addr(prt_tx_addr), .prt_tx_dat(prt_tx_dat), .prt_tx_wr(prt_tx_wr),
        .oup_rp(oup_rp), .oup_req(oup_req), .oup_ra(oup_ra),
        .cmp_valid(cmp_valid), .cmp_orig(cmp_orig), .cnt_err(cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;

    // Reference model: one held request per port, per-port in-flight counts, a pointer to the
    // port with first claim, and the queue of granted requests awaiting downstream acceptance.
    bit   m_hv [N];
    req_t m_hold [N];
    int   m_cnt [N];
    int   m_rr;
    bit   m_rp;
    bit   m_err;
    req_t sb [$];

    task automatic chk(input string nm, input req_t act, input req_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // cmode: 0 none, 1 explicit (co), 2 complete whenever something is outstanding, 3 randomly.
    task automatic cycle(input logic [N-1:0] av, input logic ra, input int cmode,
                         input logic [3:0] co_in, input bit r, input bit fixed);
        logic [31:0]  a;
        logic [127:0] d;
        logic [N-1:0] exp_re;
        logic         cv;
        logic [3:0]   co;
        bit           free;
        int           sel;
        int           p;
        int           cand [$];
        @(negedge clk);
        chk("oup_rp", req_t'(oup_rp), req_t'(m_rp));
        chk("cnt_err", req_t'(cnt_err), req_t'(m_err));
        rst       = r;
        prt_tx_av = av;
        oup_ra    = ra;
        for (int q = 0; q < N; q++) begin
            a = $urandom();
            a[3:0] = 4'h0;
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            prt_tx_addr[q*32 +: 32]  = a;
            prt_tx_dat[q*128 +: 128] = d;
            prt_tx_wr[q] = 1'($urandom_range(0, 1));
        end
        if (fixed) begin
            prt_tx_addr[31:0] = 32'h100;
            prt_tx_dat[127:0] = {16{8'hA5}};
            prt_tx_wr[0]      = 1'b1;
        end
        cv = 1'b0;
        co = co_in;
        if (cmode == 1) begin
            cv = 1'b1;
        end else if (cmode >= 2) begin
            for (int q = 0; q < N; q++) if (m_cnt[q] > 0) cand.push_back(q);
            if (cand.size() > 0 && (cmode == 2 || $urandom_range(0, 1) == 1)) begin
                cv = 1'b1;
                co = 4'(cand[$urandom_range(0, cand.size() - 1)]);
            end
        end
        cmp_valid = cv;
        cmp_orig  = co;
        #1;
        free = !m_rp || ra;
        sel  = -1;
        if (free) begin
            for (int i = 0; i < N; i++) begin
                p = (m_rr + i) % N;
                if (sel < 0 && m_hv[p] && m_cnt[p] < MAX) sel = p;
            end
        end
        for (int q = 0; q < N; q++) exp_re[q] = !m_hv[q] || (sel == q);
        chk("prt_tx_re", req_t'(prt_tx_re), req_t'(exp_re));
        if (r) begin
            for (int q = 0; q < N; q++) begin
                m_hv[q]  = 1'b0;
                m_cnt[q] = 0;
            end
            m_rr  = 0;
            m_rp  = 1'b0;
            m_err = 1'b0;
            sb.delete();
        end else begin
            if (cv) begin
                if (int'(co) >= N || m_cnt[co] == 0) m_err = 1'b1;
                else m_cnt[co]--;
            end
            if (sel >= 0) begin
                sb.push_back(m_hold[sel]);
                m_cnt[sel]++;
                m_rp = 1'b1;
                m_rr = (sel + 1) % N;
            end else if (free) begin
                m_rp = 1'b0;
            end
            for (int q = 0; q < N; q++) begin
                if (av[q] && exp_re[q]) begin
                    m_hold[q] = {prt_tx_addr[q*32 +: 32], prt_tx_dat[q*128 +: 128], 4'(q), prt_tx_wr[q]};
                    m_hv[q]   = 1'b1;
                end else if (sel == q) begin
                    m_hv[q] = 1'b0;
                end
            end
        end
    endtask

    // Monitor: every downstream acceptance must match the oldest granted request.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (oup_rp && oup_ra && !rst) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL oup_req_unexpected: got %h expected none", oup_req);
                end else begin
                    chk("oup_req", oup_req, sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; prt_tx_av = '0; prt_tx_addr = '0; prt_tx_dat = '0; prt_tx_wr = '0;
        oup_ra = 1'b0; cmp_valid = 1'b0; cmp_orig = '0;
        for (int q = 0; q < N; q++) begin
            m_hv[q] = 1'b0; m_cnt[q] = 0; m_hold[q] = '0;
        end
        m_rr = 0; m_rp = 1'b0; m_err = 1'b0;
        @(posedge clk);

        // Reset held for two cycles, then the first free cycle.
        cycle(2'b00, 1'b0, 0, 4'd0, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 0, 4'd0, 1'b1, 1'b0);
        cycle(2'b00, 1'b1, 0, 4'd0, 1'b0, 1'b0);
        chk("reset_oup_rp", req_t'(oup_rp), '0);
        chk("reset_oup_req", oup_req, '0);
        chk("reset_cnt_err", req_t'(cnt_err), '0);
        chk("reset_prt_tx_re", req_t'(prt_tx_re), req_t'(2'b11));

        // Single write on port 0: present two edges after being driven.
        cycle(2'b01, 1'b1, 0, 4'd0, 1'b0, 1'b1);
        cycle(2'b00, 1'b1, 0, 4'd0, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 0, 4'd0, 1'b0, 1'b0);
        chk("single_oup_rp", req_t'(oup_rp), req_t'(1'b1));
        chk("single_oup_req", oup_req, {32'h100, {16{8'hA5}}, 4'h0, 1'b1});

        // Fairness: both ports always requesting, completions echo grants.
        for (int i = 0; i < 20; i++) cycle(2'b11, 1'b1, 2, 4'd0, 1'b0, 1'b0);

        // Backpressure, then drain.
        for (int i = 0; i < 5; i++) cycle(2'b11, 1'b0, 0, 4'd0, 1'b0, 1'b0);
        chk("stall_prt_tx_re", req_t'(prt_tx_re), '0);
        for (int i = 0; i < 12; i++) cycle(2'b00, 1'b1, 2, 4'd0, 1'b0, 1'b0);

        // Port 1 reaches its in-flight limit; one completion releases the third request.
        for (int i = 0; i < 3; i++) cycle(2'b10, 1'b1, 0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(2'b00, 1'b1, 0, 4'd0, 1'b0, 1'b0);
        chk("limit_held", req_t'(prt_tx_re[1]), '0);
        chk("limit_idle", req_t'(oup_rp), '0);
        cycle(2'b00, 1'b1, 1, 4'd1, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 0, 4'd0, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 0, 4'd0, 1'b0, 1'b0);
        chk("limit_released", req_t'(oup_rp), req_t'(1'b1));
        for (int i = 0; i < 8; i++) cycle(2'b00, 1'b1, 2, 4'd0, 1'b0, 1'b0);

        // Completion against an idle port, out-of-range completion, reset mid-stall.
        cycle(2'b00, 1'b1, 1, 4'd0, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 0, 4'd0, 1'b0, 1'b0);
        chk("err_zero_count", req_t'(cnt_err), req_t'(1'b1));
        cycle(2'b00, 1'b1, 1, 4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(2'b11, 1'b0, 0, 4'd0, 1'b0, 1'b0);
        cycle(2'b11, 1'b0, 0, 4'd0, 1'b1, 1'b0);
        cycle(2'b00, 1'b0, 0, 4'd0, 1'b0, 1'b0);
        chk("rst_mid_oup_rp", req_t'(oup_rp), '0);
        chk("rst_mid_cnt_err", req_t'(cnt_err), '0);
        chk("rst_mid_prt_tx_re", req_t'(prt_tx_re), req_t'(2'b11));

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 3, 4'd0,
                  ($urandom_range(0, 99) == 0), 1'b0);
        end
        for (int i = 0; i < 30; i++) cycle(2'b00, 1'b1, 2, 4'd0, 1'b0, 1'b0);
        chk("drain_empty", req_t'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
